// File: rtl/mc_core.sv
// mc_core: multicycle core for 16-bit instructions. It has a 4-entry register
// file and an integrated FETCH/EXEC/MEM control FSM. Instruction and data
// memories are reached over req/ack handshakes, so wait states are tolerated.
module mc_core #(
    parameter int              DATA_W   = 16,
    parameter int              PC_W     = 16,
    parameter int              CNT_W    = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_ack,
    input  logic [15:0]       imem_data,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              halted,
    output logic              illegal,
    output logic [CNT_W-1:0]  retired,
    input  logic [1:0]        dbg_rn,
    output logic [DATA_W-1:0] dbg_rd
);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_MEM, S_STOP} state_e;

    localparam logic [5:0] OP_AR   = 6'h00;
    localparam logic [5:0] OP_ADDI = 6'h01;
    localparam logic [5:0] OP_ANDI = 6'h02;
    localparam logic [5:0] OP_LW   = 6'h03;
    localparam logic [5:0] OP_SW   = 6'h04;
    localparam logic [5:0] OP_BEQ  = 6'h05;
    localparam logic [5:0] OP_J    = 6'h06;
    localparam logic [5:0] OP_HALT = 6'h3F;

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [15:0]       ir_q, ir_d;
    logic [DATA_W-1:0] rf_q [4];
    logic [DATA_W-1:0] rf_d [4];
    logic [CNT_W-1:0]  retired_q, retired_d;
    logic              illegal_q, illegal_d;
    logic [DATA_W-1:0] daddr_q, daddr_d;
    logic [DATA_W-1:0] dwdata_q, dwdata_d;
    logic              dwe_q, dwe_d;

    // Sign-extend the 6-bit immediate to data width.
    function automatic logic [DATA_W-1:0] sext_d(input logic [5:0] v);
        return {{(DATA_W-6){v[5]}}, v};
    endfunction

    // Sign-extend the 6-bit immediate to PC width for branch offsets.
    function automatic logic [PC_W-1:0] sext_pc(input logic [5:0] v);
        return {{(PC_W-6){v[5]}}, v};
    endfunction

    logic [5:0]        opcode;
    logic [1:0]        f_t, f_s, f_s2;
    logic [3:0]        funct;
    logic [5:0]        imm;
    logic [DATA_W-1:0] rs_v, rs2_v, rt_v;
    logic [DATA_W-1:0] alu_res;
    logic              alu_ok;
    logic [PC_W-1:0]   pc_inc;

    assign opcode = ir_q[15:10];
    assign f_t    = ir_q[9:8];
    assign f_s    = ir_q[7:6];
    assign f_s2   = ir_q[5:4];
    assign funct  = ir_q[3:0];
    assign imm    = ir_q[5:0];
    assign rs_v   = rf_q[f_s];
    assign rs2_v  = rf_q[f_s2];
    assign rt_v   = rf_q[f_t];
    assign pc_inc = pc_q + PC_W'(1);

    // Register-register ALU; funct values above 5 are flagged as not legal.
    always_comb begin
        alu_res = '0;
        alu_ok  = 1'b1;
        case (funct)
            4'd0:    alu_res = rs_v + rs2_v;
            4'd1:    alu_res = rs_v - rs2_v;
            4'd2:    alu_res = rs_v & rs2_v;
            4'd3:    alu_res = rs_v | rs2_v;
            4'd4:    alu_res = rs_v ^ rs2_v;
            4'd5:    alu_res = {{(DATA_W-1){1'b0}}, ($signed(rs_v) < $signed(rs2_v))};
            default: alu_ok  = 1'b0;
        endcase
    end

    // Control FSM: next state, PC, register writeback, memory access setup.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        rf_d      = rf_q;
        retired_d = retired_q;
        illegal_d = illegal_q;
        daddr_d   = daddr_q;
        dwdata_d  = dwdata_q;
        dwe_d     = dwe_q;
        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ack) begin
                    ir_d    = imem_data;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d   = S_FETCH;
                pc_d      = pc_inc;
                retired_d = retired_q + CNT_W'(1);
                case (opcode)
                    OP_AR: begin
                        if (alu_ok) begin
                            rf_d[f_t] = alu_res;
                        end else begin
                            pc_d      = pc_q;
                            retired_d = retired_q;
                            illegal_d = 1'b1;
                            state_d   = S_STOP;
                        end
                    end
                    OP_ADDI: rf_d[f_t] = rs_v + sext_d(imm);
                    OP_ANDI: rf_d[f_t] = rs_v & DATA_W'(imm);
                    OP_LW, OP_SW: begin
                        // PC and retire count advance only once the access completes.
                        pc_d      = pc_q;
                        retired_d = retired_q;
                        daddr_d   = rs_v + sext_d(imm);
                        dwdata_d  = rt_v;
                        dwe_d     = (opcode == OP_SW);
                        state_d   = S_MEM;
                    end
                    OP_BEQ: begin
                        if (rt_v == rs_v) pc_d = pc_inc + sext_pc(imm);
                    end
                    OP_J: pc_d = PC_W'(ir_q[9:0]);
                    OP_HALT: begin
                        pc_d    = pc_q;
                        state_d = S_STOP;
                    end
                    default: begin
                        pc_d      = pc_q;
                        retired_d = retired_q;
                        illegal_d = 1'b1;
                        state_d   = S_STOP;
                    end
                endcase
            end
            S_MEM: begin
                if (dmem_ack) begin
                    if (!dwe_q) rf_d[f_t] = dmem_rdata;
                    pc_d      = pc_inc;
                    retired_d = retired_q + CNT_W'(1);
                    state_d   = S_FETCH;
                end
            end
            S_STOP: state_d = S_STOP;
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset clears everything immediately, even mid-handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            retired_q <= '0;
            illegal_q <= 1'b0;
            daddr_q   <= '0;
            dwdata_q  <= '0;
            dwe_q     <= 1'b0;
            for (int i = 0; i < 4; i++) rf_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            retired_q <= retired_d;
            illegal_q <= illegal_d;
            daddr_q   <= daddr_d;
            dwdata_q  <= dwdata_d;
            dwe_q     <= dwe_d;
            rf_q      <= rf_d;
        end
    end

    assign imem_req   = (state_q == S_FETCH);
    assign imem_addr  = pc_q;
    assign dmem_req   = (state_q == S_MEM);
    assign dmem_we    = dwe_q;
    assign dmem_addr  = daddr_q;
    assign dmem_wdata = dwdata_q;
    assign halted     = (state_q == S_STOP);
    assign illegal    = illegal_q;
    assign retired    = retired_q;
    assign dbg_rd     = rf_q[dbg_rn];

endmodule

// File: tb/tb_mc_core.sv
// tb_mc_core: randomized and directed bench for mc_core against an
// instruction-level reference model with wait-state memory responders.
module tb_mc_core;

    localparam int              DATA_W   = 16;
    localparam int              PC_W     = 10;
    localparam int              CNT_W    = 6;
    localparam logic [PC_W-1:0] RESET_PC = 10'h004;

    logic              clk, rst, run;
    logic              imem_req, imem_ack;
    logic [PC_W-1:0]   imem_addr;
    logic [15:0]       imem_data;
    logic              dmem_req, dmem_we, dmem_ack;
    logic [DATA_W-1:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic              halted, illegal;
    logic [CNT_W-1:0]  retired;
    logic [1:0]        dbg_rn;
    logic [DATA_W-1:0] dbg_rd;

    mc_core #(.DATA_W(DATA_W), .PC_W(PC_W), .CNT_W(CNT_W), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst), .run(run),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .halted(halted), .illegal(illegal), .retired(retired),
        .dbg_rn(dbg_rn), .dbg_rd(dbg_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [15:0]       imem [1024];
    logic [DATA_W-1:0] dmem [65536];
    logic [DATA_W-1:0] mmem [65536];

    // reference model state
    logic [DATA_W-1:0] mr [4];
    logic [PC_W-1:0]   mpc;
    int                mret, mexec, mcycles;
    bit                mstop, millegal, mpend, exp_we;
    logic [DATA_W-1:0] exp_addr, exp_wdata;
    int                exp_t;

    // responder state
    bit                ibusy, iacked, dbusy, dacked, spur;
    int                iwait, iw0, dwait, dw0, dcnt, imax, dmax, ifixed, dfixed;
    logic [PC_W-1:0]   iaddr0, last_fetch;
    logic [DATA_W-1:0] da0, dwd0;
    bit                dwe0;
    int                cyc, halt_cyc;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] enc(input int op, input int t, input int s, input int lo);
        return {op[5:0], t[1:0], s[1:0], lo[5:0]};
    endfunction

    function automatic logic [15:0] ar(input int t, input int s1, input int s2, input int f);
        return enc(0, t, s1, s2 * 16 + f);
    endfunction

    task automatic tb_clear();
        for (int i = 0; i < 4; i++) mr[i] = '0;
        mpc = RESET_PC; mret = 0; mexec = 0; mcycles = 0;
        mstop = 0; millegal = 0; mpend = 0;
        ibusy = 0; iacked = 0; dbusy = 0; dacked = 0; dcnt = 0;
    endtask

    // Execute one fetched instruction at the architectural level.
    task automatic model_exec(input logic [15:0] w, input int iw);
        int op, t, s, s2, f, simm;
        logic [DATA_W-1:0] a, b, sx;
        op = int'(w[15:10]); t = int'(w[9:8]); s = int'(w[7:6]);
        s2 = int'(w[5:4]); f = int'(w[3:0]);
        simm = w[5] ? int'(w[5:0]) - 64 : int'(w[5:0]);
        sx = DATA_W'(simm);
        a = mr[s]; b = mr[s2];
        mexec++;
        mcycles += 2 + iw;
        case (op)
            0: begin
                if (f <= 5) begin
                    case (f)
                        0: mr[t] = a + b;
                        1: mr[t] = a - b;
                        2: mr[t] = a & b;
                        3: mr[t] = a | b;
                        4: mr[t] = a ^ b;
                        default: mr[t] = ($signed(a) < $signed(b)) ? DATA_W'(1) : DATA_W'(0);
                    endcase
                    mpc = mpc + 1'b1; mret++;
                end else begin
                    millegal = 1; mstop = 1;
                end
            end
            1: begin mr[t] = a + sx; mpc = mpc + 1'b1; mret++; end
            2: begin mr[t] = a & DATA_W'(w[5:0]); mpc = mpc + 1'b1; mret++; end
            3, 4: begin
                exp_addr = a + sx; exp_we = (op == 4); exp_wdata = mr[t]; exp_t = t; mpend = 1;
            end
            5: begin
                if (mr[t] == mr[s]) mpc = PC_W'(int'(mpc) + 1 + simm);
                else mpc = mpc + 1'b1;
                mret++;
            end
            6: begin mpc = w[9:0]; mret++; end
            63: begin mret++; mstop = 1; end
            default: begin millegal = 1; mstop = 1; end
        endcase
    endtask

    task automatic model_mem_done(input int dw);
        if (exp_we) mmem[exp_addr] = exp_wdata;
        else mr[exp_t] = mmem[exp_addr];
        mpc = mpc + 1'b1; mret++; mpend = 0;
        mcycles += 1 + dw;
    endtask

    // One clock: observe DUT at the falling edge, then drive both memory responders.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (halted && halt_cyc < 0) halt_cyc = cyc;
        chk("req_excl", 64'(imem_req & dmem_req), 64'(0));
        // instruction memory
        if (iacked) begin
            chk("imem_req_drop", 64'(imem_req), 64'(0));
            iacked = 0; ibusy = 0;
        end else if (ibusy) begin
            chk("imem_req_held", 64'(imem_req), 64'(1));
            if (!imem_req) ibusy = 0;
        end
        if (imem_req && !ibusy) begin
            ibusy = 1;
            iwait = (ifixed >= 0) ? ifixed : int'($urandom_range(imax, 0));
            iw0 = iwait; iaddr0 = imem_addr;
            chk("fetch_pc", 64'(imem_addr), 64'(mpc));
            chk("retired", 64'(retired), 64'(mret % (1 << CNT_W)));
            dbg_rn = 2'($urandom_range(3, 0));
            #1 chk("dbg_reg", 64'(dbg_rd), 64'(mr[dbg_rn]));
        end else if (imem_req) begin
            chk("imem_addr_stable", 64'(imem_addr), 64'(iaddr0));
        end
        if (imem_req && ibusy) begin
            if (iwait == 0) begin
                imem_ack = 1'b1; imem_data = imem[imem_addr]; last_fetch = imem_addr;
                model_exec(imem_data, iw0);
                iacked = 1;
            end else begin
                imem_ack = 1'b0; iwait--;
            end
        end else begin
            imem_ack = spur ? 1'($urandom_range(1, 0)) : 1'b0;
            imem_data = 16'($urandom);
        end
        // data memory
        if (dacked) begin
            chk("dmem_req_drop", 64'(dmem_req), 64'(0));
            chk("dmem_req_len", 64'(dcnt), 64'(dw0 + 1));
            dacked = 0; dbusy = 0;
        end else if (dbusy) begin
            chk("dmem_req_held", 64'(dmem_req), 64'(1));
            if (!dmem_req) dbusy = 0;
        end
        if (dmem_req && !dbusy) begin
            dbusy = 1; dcnt = 0;
            dwait = (dfixed >= 0) ? dfixed : int'($urandom_range(dmax, 0));
            dw0 = dwait; da0 = dmem_addr; dwe0 = dmem_we; dwd0 = dmem_wdata;
            chk("dmem_pending", 64'(mpend), 64'(1));
            chk("dmem_addr", 64'(dmem_addr), 64'(exp_addr));
            chk("dmem_we", 64'(dmem_we), 64'(exp_we));
            if (exp_we) chk("dmem_wdata", 64'(dmem_wdata), 64'(exp_wdata));
        end else if (dmem_req) begin
            chk("dmem_addr_stable", 64'(dmem_addr), 64'(da0));
            chk("dmem_we_stable", 64'(dmem_we), 64'(dwe0));
            chk("dmem_wdata_stable", 64'(dmem_wdata), 64'(dwd0));
        end
        if (dmem_req && dbusy) begin
            dcnt++;
            if (dwait == 0) begin
                dmem_ack = 1'b1;
                if (dmem_we) dmem[dmem_addr] = dmem_wdata;
                else dmem_rdata = dmem[dmem_addr];
                model_mem_done(dw0);
                dacked = 1;
            end else begin
                dmem_ack = 1'b0; dwait--;
            end
        end else begin
            dmem_ack = spur ? 1'($urandom_range(1, 0)) : 1'b0;
            dmem_rdata = DATA_W'($urandom);
        end
    endtask

    task automatic check_regs(input string nm);
        for (int i = 0; i < 4; i++) begin
            dbg_rn = 2'(i);
            #1 chk($sformatf("%s_r%0d", nm, i), 64'(dbg_rd), 64'(mr[i]));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        tb_clear();
        @(negedge clk);
        chk("rst_imem_req", 64'(imem_req), 64'(0));
        chk("rst_dmem_req", 64'(dmem_req), 64'(0));
        chk("rst_dmem_we", 64'(dmem_we), 64'(0));
        chk("rst_halted", 64'(halted), 64'(0));
        chk("rst_illegal", 64'(illegal), 64'(0));
        chk("rst_retired", 64'(retired), 64'(0));
        check_regs("rst");
        rst = 1'b1;
    endtask

    task automatic start();
        @(negedge clk);
        run = 1'b1; cyc = 0; halt_cyc = -1;
    endtask

    task automatic run_prog(input int exec_lim, input int cyc_lim);
        int n;
        n = 0;
        while (!halted && mexec < exec_lim && n < cyc_lim) begin
            step(); n++;
        end
        if (n >= cyc_lim) chk("run_timeout", 64'(n), 64'(0));
    endtask

    task automatic finish_checks(input string nm);
        repeat (3) begin
            step();
            chk({nm, "_no_fetch"}, 64'(imem_req), 64'(0));
        end
        chk({nm, "_halted"}, 64'(halted), 64'(1));
        chk({nm, "_illegal"}, 64'(illegal), 64'(millegal));
        chk({nm, "_retired"}, 64'(retired), 64'(mret % (1 << CNT_W)));
        chk({nm, "_latency"}, 64'(halt_cyc), 64'(mcycles + 1));
        check_regs(nm);
    endtask

    task automatic fill_imem();
        for (int i = 0; i < 1024; i++) imem[i] = 16'h1C00;
    endtask

    logic [15:0] w;
    int n, op_sel;

    initial begin
        rst = 1'b0; run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        imem_data = '0; dmem_rdata = '0; dbg_rn = '0;
        spur = 0; imax = 0; dmax = 0; ifixed = 0; dfixed = 0;
        for (int i = 0; i < 65536; i++) begin
            dmem[i] = DATA_W'($urandom); mmem[i] = dmem[i];
        end

        // ADDI then HALT, zero-wait fetch
        fill_imem();
        imem[4] = enc(1, 1, 0, 5);
        imem[5] = 16'hFC00;
        do_reset(); start(); run_prog(1000, 500);
        finish_checks("t1");
        dbg_rn = 2'd1;
        #1 chk("t1_r1_is_5", 64'(dbg_rd), 64'(5));
        chk("t1_retired_2", 64'(retired), 64'(2));
        chk("t1_halt_cycle", 64'(halt_cyc), 64'(5));

        // ALU sequence with results stored to memory
        fill_imem();
        imem[4]  = enc(1, 1, 0, 7);
        imem[5]  = enc(1, 2, 0, 63);
        imem[6]  = ar(3, 1, 2, 0);
        imem[7]  = enc(4, 3, 0, 10);
        imem[8]  = ar(3, 2, 1, 5);
        imem[9]  = enc(4, 3, 0, 11);
        imem[10] = ar(3, 1, 1, 1);
        imem[11] = 16'hFC00;
        do_reset(); start(); run_prog(1000, 500);
        finish_checks("t2");
        chk("t2_add_wrap", 64'(dmem[10]), 64'(6));
        chk("t2_slt_signed", 64'(dmem[11]), 64'(1));
        dbg_rn = 2'd3;
        #1 chk("t2_sub_zero", 64'(dbg_rd), 64'(0));

        // store then load through a 2-wait data memory
        fill_imem();
        imem[4] = enc(1, 1, 0, 7);
        imem[5] = enc(4, 1, 0, 3);
        imem[6] = enc(3, 2, 0, 3);
        imem[7] = 16'hFC00;
        dfixed = 2;
        do_reset(); start(); run_prog(1000, 500);
        finish_checks("t3");
        chk("t3_mem3", 64'(dmem[3]), 64'(7));
        dbg_rn = 2'd2;
        #1 chk("t3_r2_loaded", 64'(dbg_rd), 64'(7));

        // branches, jump to top of PC space, wrap to 0
        fill_imem();
        imem[4]     = enc(1, 1, 0, 1);
        imem[5]     = enc(5, 0, 1, 5);
        imem[6]     = enc(5, 0, 0, 2);
        imem[9]     = {6'h06, 10'h3FF};
        imem[10'h3FF] = enc(1, 2, 0, 3);
        imem[0]     = 16'hFC00;
        dfixed = 0;
        do_reset(); start(); run_prog(1000, 500);
        finish_checks("t4");
        chk("t4_retired_6", 64'(retired), 64'(6));
        chk("t4_wrap_fetch", 64'(last_fetch), 64'(0));

        // illegal opcode 0x07
        fill_imem();
        imem[4] = enc(1, 1, 0, 1);
        imem[5] = 16'h1C00;
        do_reset(); start(); run_prog(1000, 500);
        finish_checks("t5");
        chk("t5_illegal", 64'(illegal), 64'(1));
        chk("t5_retired_1", 64'(retired), 64'(1));

        // reset while a store is waiting for its ack
        fill_imem();
        imem[4] = enc(1, 1, 0, 9);
        imem[5] = enc(4, 1, 0, 2);
        imem[6] = 16'hFC00;
        dfixed = 6;
        do_reset(); start();
        n = 0;
        while (!dmem_req && n < 100) begin step(); n++; end
        chk("t6_dreq_seen", 64'(dmem_req), 64'(1));
        step(); step();
        #2 rst = 1'b0;
        #1 chk("t6_dreq_drop", 64'(dmem_req), 64'(0));
        chk("t6_ireq_low", 64'(imem_req), 64'(0));
        chk("t6_retired_clr", 64'(retired), 64'(0));
        dbg_rn = 2'd1;
        #1 chk("t6_r1_clr", 64'(dbg_rd), 64'(0));
        run = 1'b0;
        dmem_ack = 1'b1; dmem_rdata = DATA_W'($urandom);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("t6_late_ack_dreq", 64'(dmem_req), 64'(0));
            chk("t6_late_ack_ireq", 64'(imem_req), 64'(0));
        end
        dmem_ack = 1'b0;
        tb_clear(); dfixed = 0;
        start(); run_prog(1000, 500);
        finish_checks("t6");
        chk("t6_store_done", 64'(dmem[2]), 64'(9));

        // random programs with random wait states and stray acks
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < 1024; i++) begin
                op_sel = int'($urandom_range(99, 0));
                w = 16'($urandom);
                if (op_sel < 25) w[15:10] = 6'h00;
                else if (op_sel < 40) w[15:10] = 6'h01;
                else if (op_sel < 48) w[15:10] = 6'h02;
                else if (op_sel < 60) w[15:10] = 6'h03;
                else if (op_sel < 72) w[15:10] = 6'h04;
                else if (op_sel < 86) w[15:10] = 6'h05;
                else if (op_sel < 93) w[15:10] = 6'h06;
                else if (op_sel < 97) w[15:10] = 6'h3F;
                else w[15:10] = 6'($urandom_range(62, 7));
                if (w[15:10] == 6'h00 && op_sel < 23) w[3:0] = 4'($urandom_range(5, 0));
                imem[i] = w;
            end
            spur = 1; ifixed = -1; dfixed = -1;
            imax = int'($urandom_range(3, 0)); dmax = int'($urandom_range(3, 0));
            do_reset(); start(); run_prog(200, 6000);
            if (halted) finish_checks($sformatf("rand%0d", k));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
